thermal_throttle_ctrl: RTL and testbench

//  Sequences the 32-bit RISC pipeline under thermal control. Maps temp_st to a throttle level and

---
 rtl/thermal_throttle_ctrl_pkg.sv | 39 +++
 rtl/thermal_throttle_ctrl_if.sv | 15 +
 rtl/thermal_throttle_ctrl_ce_divider.sv | 29 ++
 rtl/thermal_throttle_ctrl.sv | 111 +++++++++++
 tb/tb_thermal_throttle_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/thermal_throttle_ctrl_pkg.sv
// Shared encodings for the thermal throttle controller: temperature codes,
// throttle levels, FSM states and small decode helpers.
package thermal_pkg;

  localparam logic [2:0] TEMP_EQ    = 3'b000;
  localparam logic [2:0] TEMP_SMALL = 3'b001;
  localparam logic [2:0] TEMP_LG    = 3'b010;
  localparam logic [2:0] TEMP_EXT   = 3'b011;

  typedef logic [1:0] lvl_t;
  localparam lvl_t LVL_DIV1 = 2'd0;
  localparam lvl_t LVL_DIV2 = 2'd1;
  localparam lvl_t LVL_DIV4 = 2'd2;

  typedef enum logic [1:0] {RUN, DRAIN, STOP} state_t;

  // Any code with the top bit set is as bad as the extreme code.
  function automatic logic temp_is_ext(input logic [2:0] t);
    return t[2] || (t == TEMP_EXT);
  endfunction

  function automatic lvl_t temp_target(input logic [2:0] t);
    case (t)
      TEMP_SMALL: return LVL_DIV2;
      TEMP_LG:    return LVL_DIV4;
      default:    return LVL_DIV1;
    endcase
  endfunction

  // Terminal divider count (div-1) for a level.
  function automatic lvl_t div_max(input lvl_t l);
    case (l)
      LVL_DIV1: return 2'd0;
      LVL_DIV2: return 2'd1;
      default:  return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/thermal_throttle_ctrl_if.sv
// Pipeline-side signals of the thermal throttle controller.
interface thermal_throttle_ctrl_if;
  logic [2:0] temp_st;
  logic       halted;
  logic       pipe_idle;
  logic       pipe_ce;
  logic       fetch_hold;
  logic [1:0] level;
  logic       stopped;

  modport master (output temp_st, halted, pipe_idle,
                  input  pipe_ce, fetch_hold, level, stopped);
  modport slave  (input  temp_st, halted, pipe_idle,
                  output pipe_ce, fetch_hold, level, stopped);
endinterface

// File: rtl/thermal_throttle_ctrl_ce_divider.sv
// Registered pipeline clock-enable at 1/1, 1/2 or 1/4 rate; owns div_cnt.
module thermal_ce_divider
  import thermal_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  lvl_t level,
  input  logic restart,
  input  logic gate,
  output logic pipe_ce
);

  lvl_t div_cnt;

  // gate suppresses only the enable pulse; the phase keeps running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pipe_ce <= 1'b0;
    end else if (restart || (div_cnt == div_max(level))) begin
      div_cnt <= '0;
      pipe_ce <= !gate;
    end else begin
      div_cnt <= div_cnt + 2'd1;
      pipe_ce <= 1'b0;
    end
  end

endmodule

// File: rtl/thermal_throttle_ctrl.sv
// Thermal throttle controller: maps temperature to a throttle level with
// hysteresis, drains and stops the pipeline on extreme temperature.
module thermal_throttle_ctrl
  import thermal_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int HCNT_W      = 5
)(
  input logic                    clk,
  input logic                    rst_n,
  thermal_throttle_ctrl_if.slave tif
);

  state_t            state;
  lvl_t              level;
  lvl_t              tgt;
  logic [HCNT_W-1:0] hold_cnt;
  logic [HCNT_W-1:0] hold_inc;
  logic              fetch_hold;
  logic              stopped;
  logic              pipe_ce;

  logic stop_req, hold_exp, raise, step_dn, drain_go, drain_done, stop_exit;
  logic restart, gate;

  always_comb begin
    tgt        = temp_target(tif.temp_st);
    stop_req   = temp_is_ext(tif.temp_st);
    hold_inc   = hold_cnt + 1'b1;
    hold_exp   = (hold_inc == HCNT_W'(HOLD_CYCLES));
    raise      = (state == RUN) && !stop_req && (tgt > level);
    step_dn    = (state == RUN) && !stop_req && (tgt < level) && hold_exp;
    drain_go   = (state == RUN) && stop_req;
    drain_done = (state == DRAIN) && tif.pipe_idle && pipe_ce;
    stop_exit  = (state == STOP) && !stop_req && hold_exp;
  end

  // Any level change re-phases the divider; leaving STOP also re-phases it so
  // the first RUN cycle after a thermal stop issues an enable immediately.
  assign restart = raise || step_dn || (drain_go && (level != LVL_DIV4)) || stop_exit;
  assign gate    = tif.halted || drain_done || ((state == STOP) && !stop_exit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      level      <= LVL_DIV1;
      hold_cnt   <= '0;
      fetch_hold <= 1'b0;
      stopped    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (stop_req) begin
            state      <= DRAIN;
            level      <= LVL_DIV4;
            hold_cnt   <= '0;
            fetch_hold <= 1'b1;
          end else if (raise) begin
            level    <= tgt;
            hold_cnt <= '0;
          end else if (tgt < level) begin
            if (hold_exp) begin
              level    <= level - 2'd1;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_inc;
            end
          end else begin
            hold_cnt <= '0;
          end
        end
        // Once started, draining completes even if the temperature recovers.
        DRAIN: begin
          if (drain_done) begin
            state   <= STOP;
            stopped <= 1'b1;
          end
        end
        STOP: begin
          if (stop_req) begin
            hold_cnt <= '0;
          end else if (hold_exp) begin
            state      <= RUN;
            level      <= LVL_DIV4;
            hold_cnt   <= '0;
            fetch_hold <= 1'b0;
            stopped    <= 1'b0;
          end else begin
            hold_cnt <= hold_inc;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  thermal_ce_divider u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .level   (level),
    .restart (restart),
    .gate    (gate),
    .pipe_ce (pipe_ce)
  );

  assign tif.pipe_ce    = pipe_ce;
  assign tif.fetch_hold = fetch_hold;
  assign tif.level      = level;
  assign tif.stopped    = stopped;

endmodule

// File: tb/tb_thermal_throttle_ctrl.sv
// Directed bench for thermal_throttle_ctrl: a cycle model pushes expected
// outputs to a scoreboard, popped and checked after each clock edge.
module tb_thermal_throttle_ctrl;

  localparam logic [2:0] EQ = 3'b000, SM = 3'b001, LG = 3'b010, EXT = 3'b011;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  thermal_throttle_ctrl_if tif ();

  thermal_throttle_ctrl #(.HOLD_CYCLES(16), .HCNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tif   (tif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       ce;
    logic [1:0] lvl;
    logic       fh;
    logic       st;
  } exp_t;
  exp_t sb[$];

  // Reference model state: 0 RUN, 1 DRAIN, 2 STOP
  int m_state, m_level, m_hold, m_cnt;
  bit m_ce;

  task automatic model_reset();
    m_state = 0; m_level = 0; m_hold = 0; m_cnt = 0; m_ce = 1'b0;
  endtask

  task automatic model_edge(input logic [2:0] t, input logic h, input logic idle);
    bit ext;
    int tg, nl, nh, ns;
    bit off, rs;
    ext = (t[2] == 1'b1) || (t == 3'b011);
    tg  = ext ? 3 : int'(t[1:0]);
    nl  = m_level; nh = m_hold; ns = m_state;
    off = h; rs = 1'b0;
    if (m_state == 0) begin
      if (ext) begin ns = 1; nl = 2; nh = 0; end
      else if (tg > m_level) begin nl = tg; nh = 0; end
      else if (tg < m_level) begin
        nh = m_hold + 1;
        if (nh == 16) begin nl = m_level - 1; nh = 0; end
      end else nh = 0;
    end else if (m_state == 1) begin
      if (idle && m_ce) begin ns = 2; off = 1'b1; end
    end else begin
      if (ext) begin nh = 0; off = 1'b1; end
      else if (m_hold + 1 == 16) begin ns = 0; nl = 2; nh = 0; rs = 1'b1; end
      else begin nh = m_hold + 1; off = 1'b1; end
    end
    if (nl != m_level) rs = 1'b1;
    if (rs || m_cnt == (1 << m_level) - 1) begin m_cnt = 0; m_ce = !off; end
    else begin m_cnt = m_cnt + 1; m_ce = 1'b0; end
    m_state = ns; m_level = nl; m_hold = nh;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] pat;

  task automatic cyc(input logic [2:0] t, input logic h = 1'b0, input logic idle = 1'b0);
    exp_t e;
    tif.temp_st = t; tif.halted = h; tif.pipe_idle = idle;
    model_edge(t, h, idle);
    e.ce = m_ce; e.lvl = 2'(m_level); e.fh = (m_state != 0); e.st = (m_state == 2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pipe_ce", 8'(tif.pipe_ce), 8'(e.ce));
    chk("level", 8'(tif.level), 8'(e.lvl));
    chk("fetch_hold", 8'(tif.fetch_hold), 8'(e.fh));
    chk("stopped", 8'(tif.stopped), 8'(e.st));
    pat = {pat[2:0], tif.pipe_ce};
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ce"}, 8'(tif.pipe_ce), 8'd0);
    chk({tag, "_lvl"}, 8'(tif.level), 8'd0);
    chk({tag, "_fh"}, 8'(tif.fetch_hold), 8'd0);
    chk({tag, "_st"}, 8'(tif.stopped), 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; tif.temp_st = EQ; tif.halted = 1'b0; tif.pipe_idle = 1'b0;
    model_reset();
    pat = '0;

    // 1. reset, then full rate
    repeat (3) @(posedge clk);
    #1 chk_reset_outs("rst");
    @(negedge clk) rst_n = 1'b1;
    repeat (4) cyc(EQ);
    chk("full_rate", 8'(pat), 8'hf);

    // 2. raises take effect on the next edge
    repeat (4) cyc(SM);
    chk("div2_pat", 8'(pat), 8'ha);
    chk("div2_lvl", 8'(tif.level), 8'd1);
    repeat (4) cyc(LG);
    chk("div4_pat", 8'(pat), 8'h8);
    chk("div4_lvl", 8'(tif.level), 8'd2);

    // 3. hysteresis with a restart at hold cycle 10
    repeat (10) cyc(EQ);
    cyc(LG);
    repeat (15) cyc(EQ);
    chk("hold_restart_lvl2", 8'(tif.level), 8'd2);
    cyc(EQ);
    chk("step_to_1", 8'(tif.level), 8'd1);
    repeat (15) cyc(EQ);
    chk("hold_lvl1", 8'(tif.level), 8'd1);
    cyc(EQ);
    chk("step_to_0", 8'(tif.level), 8'd0);

    // 4. extreme temperature: drain then stop
    repeat (4) cyc(LG);
    cyc(EXT);
    chk("drain_fh", 8'(tif.fetch_hold), 8'd1);
    repeat (4) cyc(EXT);
    for (int i = 0; i < 8 && !tif.stopped; i++) cyc(EXT, 1'b0, 1'b1);
    chk("stop_reached", 8'(tif.stopped), 8'd1);
    chk("stop_ce", 8'(tif.pipe_ce), 8'd0);

    // 5. leaving STOP, with a 1xx code clearing the hold count
    repeat (10) cyc(SM);
    cyc(3'b101);
    repeat (15) cyc(SM);
    chk("stop_held", 8'(tif.stopped), 8'd1);
    cyc(SM);
    chk("stop_exit", 8'(tif.stopped), 8'd0);
    chk("stop_exit_lvl", 8'(tif.level), 8'd2);
    repeat (15) cyc(SM);
    chk("post_stop_lvl2", 8'(tif.level), 8'd2);
    cyc(SM);
    chk("post_stop_lvl1", 8'(tif.level), 8'd1);

    // 6. async reset mid-DRAIN, then halt at level 0
    repeat (3) cyc(EXT);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("async_rst");
    model_reset();
    sb.delete();
    tif.temp_st = EQ;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) cyc(EQ);
    chk("resume_full", 8'(pat[2:0]), 8'h7);
    repeat (3) cyc(EQ, 1'b1);
    chk("halt_ce", 8'(pat[2:0]), 8'h0);
    chk("halt_lvl", 8'(tif.level), 8'd0);
    repeat (2) cyc(EQ);
    chk("unhalt_ce", 8'(pat[1:0]), 8'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
